// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus: EX/ID hazard inputs, interrupt handshake and pipeline
// control outputs grouped so the controller and its user share one port.
interface pipeline_hazard_ctrl_if;
  logic       ex_RF_WR;
  logic [1:0] ex_RF_WR_SEL;
  logic [4:0] ex_WB_ADDR;
  logic [4:0] id_src_x;
  logic [4:0] id_src_y;
  logic       id_uses_x;
  logic       id_uses_y;
  logic       ex_branch_taken;
  logic       int_req;
  logic       i_enable;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       nop;
  logic       interupt;
  logic       int_ack;

  // Pipeline side: drives hazard/interrupt inputs, consumes control outputs.
  modport master (
    output ex_RF_WR, ex_RF_WR_SEL, ex_WB_ADDR, id_src_x, id_src_y, id_uses_x, id_uses_y,
    output ex_branch_taken, int_req, i_enable,
    input  pc_stall, if_id_stall, if_id_flush, nop, interupt, int_ack
  );

  // Controller side.
  modport slave (
    input  ex_RF_WR, ex_RF_WR_SEL, ex_WB_ADDR, id_src_x, id_src_y, id_uses_x, id_uses_y,
    input  ex_branch_taken, int_req, i_enable,
    output pc_stall, if_id_stall, if_id_flush, nop, interupt, int_ack
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use stall and interrupt
// injection sequencing. Outputs are combinational in state, cnt and inputs.
module pipeline_hazard_ctrl (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StRun,
    StFlush,
    StIntDrain,
    StIntInject,
    StIntWait
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic load_hazard;
  logic pc_stall_c, if_id_stall_c, if_id_flush_c, nop_c, interupt_c, int_ack_c;

  // Load in EX feeding a source operand the ID instruction actually reads.
  always_comb begin
    load_hazard = bus.ex_RF_WR && (bus.ex_RF_WR_SEL == 2'h1) &&
                  ((bus.id_uses_x && (bus.id_src_x == bus.ex_WB_ADDR)) ||
                   (bus.id_uses_y && (bus.id_src_y == bus.ex_WB_ADDR)));
  end

  // State and counter registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and raw control outputs. The entry cycle in RUN counts as the
  // first flush/drain cycle, so the follow-on state lasts while cnt counts 1->0.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    nop_c         = 1'b0;
    interupt_c    = 1'b0;
    int_ack_c     = 1'b0;
    case (state_q)
      StRun: begin
        if (bus.ex_branch_taken) begin
          if_id_flush_c = 1'b1;
          nop_c         = 1'b1;
          cnt_d         = 2'd1;
          state_d       = StFlush;
        end else if (load_hazard) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          nop_c         = 1'b1;
        end else if (bus.int_req && bus.i_enable) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          nop_c         = 1'b1;
          cnt_d         = 2'd1;
          state_d       = StIntDrain;
        end
      end
      StFlush: begin
        if_id_flush_c = 1'b1;
        nop_c         = 1'b1;
        cnt_d         = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = StRun;
        end
      end
      StIntDrain: begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        nop_c         = 1'b1;
        cnt_d         = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = StIntInject;
        end
      end
      StIntInject: begin
        interupt_c = 1'b1;
        int_ack_c  = 1'b1;
        pc_stall_c = 1'b1;
        state_d    = StIntWait;
      end
      StIntWait: begin
        if_id_flush_c = 1'b1;
        nop_c         = 1'b1;
        state_d       = StRun;
      end
      default: begin
        cnt_d   = 2'd0;
        state_d = StRun;
      end
    endcase
  end

  // Outputs are forced low while reset is held, even if inputs show a hazard.
  always_comb begin
    bus.pc_stall    = rst_n & pc_stall_c;
    bus.if_id_stall = rst_n & if_id_stall_c;
    bus.if_id_flush = rst_n & if_id_flush_c;
    bus.nop         = rst_n & nop_c;
    bus.interupt    = rst_n & interupt_c;
    bus.int_ack     = rst_n & int_ack_c;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset; all state SHALL clear immediately when rst_n falls.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: ex_RF_WR  input  1  the instruction in EX writes the register file.
REQ-005 Port: ex_RF_WR_SEL  input  2  EX write-back source; 2'h1 = scratch-memory read (load).
REQ-006 Port: ex_WB_ADDR  input  5  destination register of the EX instruction.
REQ-007 Port: id_src_x, id_src_y  input  5 each  source registers of the ID instruction.
REQ-008 Port: id_uses_x, id_uses_y  input  1 each  ID instruction reads src_x / src_y.
REQ-009 Port: ex_branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-010 Port: int_req  input  1  level interrupt request.
REQ-011 Port: i_enable  input  1  interrupt-enable flag.
REQ-012 Port: pc_stall  output  1  hold the PC.
REQ-013 Port: if_id_stall  output  1  hold the IF/ID register.
REQ-014 Port: if_id_flush  output  1  zero the IF/ID register.
REQ-015 Port: nop  output  1  bubble request to the ID/EX control-vector register.
REQ-016 Port: interupt  output  1  interrupt-vector injection request to the ID/EX control-vector register.
REQ-017 Port: int_ack  output  1  one-cycle acknowledge to the interrupt source.

Function
REQ-018 The FSM SHALL have states RUN, FLUSH, INT_DRAIN, INT_INJECT and INT_WAIT, and a 2-bit counter cnt.
REQ-019 load_hazard SHALL be defined as ex_RF_WR & (ex_RF_WR_SEL==2'h1) & ((id_uses_x & id_src_x==ex_WB_ADDR) | (id_uses_y & id_src_y==ex_WB_ADDR)).
REQ-020 In RUN with ex_branch_taken=1, the block SHALL assert if_id_flush and nop in the same cycle, load cnt=1, and go to FLUSH.
REQ-021 In FLUSH, the block SHALL assert if_id_flush and nop, decrement cnt, and return to RUN when cnt==0, giving exactly 2 flush cycles in total.
REQ-022 In RUN with no branch and load_hazard=1, the block SHALL assert pc_stall, if_id_stall and nop for that cycle only and remain in RUN; the hazard clears naturally on the next cycle.
REQ-023 In RUN with no branch, no load_hazard, and int_req & i_enable = 1, the block SHALL go to INT_DRAIN with cnt=1 and assert pc_stall, if_id_stall and nop in that cycle.
REQ-024 In INT_DRAIN, the block SHALL assert pc_stall, if_id_stall and nop, decrement cnt, and go to INT_INJECT when cnt==0, giving 2 drain cycles.
REQ-025 In INT_INJECT, the block SHALL assert interupt, int_ack and pc_stall for exactly one cycle (nop=0), then go to INT_WAIT.
REQ-026 In INT_WAIT, the block SHALL assert if_id_flush and nop for one cycle, then go to RUN.
REQ-027 Priority in RUN SHALL be: branch, then load_hazard, then interrupt; an interrupt that loses priority SHALL be re-evaluated on the next RUN cycle.
REQ-028 Once INT_DRAIN is entered, the sequence SHALL complete even if int_req or i_enable deasserts.
REQ-029 ex_branch_taken in FLUSH or INT_* states SHALL be ignored.
REQ-030 interupt and nop SHALL never both be 1 in the same cycle.
REQ-031 All outputs SHALL be combinational functions of the state, cnt and the current inputs; there SHALL be no other latency.

Reset
REQ-032 With rst_n=0, the block SHALL hold state=RUN and cnt=0, and all outputs SHALL be 0.
REQ-033 Reset asserted mid-sequence (FLUSH or INT_*) SHALL abort the sequence without issuing int_ack; operation SHALL resume in RUN on the first clock edge after rst_n rises.

Verification
REQ-034 Load-use: ex_RF_WR=1, ex_RF_WR_SEL=2'h1, ex_WB_ADDR=5, id_src_x=5, id_uses_x=1 -> pc_stall=if_id_stall=nop=1 for exactly 1 cycle; with id_uses_x=0 -> no stall.
REQ-035 Branch: ex_branch_taken pulse in RUN -> if_id_flush=nop=1 for exactly 2 cycles, then all outputs 0.
REQ-036 Interrupt: int_req=1, i_enable=1 in idle RUN -> 2 cycles of stall+nop, 1 cycle of interupt=int_ack=1, 1 cycle of flush+nop, then RUN; the sequence is 4 cycles in total. With i_enable=0 -> no response.
REQ-037 Simultaneous: branch, load_hazard and int_req in the same cycle -> flush for 2 cycles, then the interrupt sequence starts on the following cycle if int_req is still high.
REQ-038 Reset: rst_n pulled low during INT_DRAIN -> outputs go to 0 immediately, with no int_ack; after release, the idle bench shows all outputs 0.
REQ-039 Drop: int_req falls during INT_DRAIN -> int_ack is still issued on schedule.
